// File: rtl/pool1_ctrl_if.sv
// pool1_ctrl_if -- memory-side bundle of the pool-1 sequencer.
//
// Groups the two conv-1 read ports (shared strobe, per-lane address and
// data) and the two P1 write ports (per-lane enable, address, data).
//
//   c1_rd_en                  controller -> conv mem   read strobe (both lanes)
//   c1_rd_addr0/1   [9:0]     controller -> conv mem   per-lane read address
//   c1_rd_data0/1   [DATA_W]  conv mem   -> controller per-lane read data
//   p1_we0/1                  controller -> P1 mem     per-lane write enable
//   p1_wr_addr0/1   [7:0]     controller -> P1 mem     per-lane write address
//   p1_wr_data0/1   [DATA_W]  controller -> P1 mem     per-lane write data
//
// master: the controller (pool1_ctrl); slave: the memory side.
interface pool1_ctrl_if #(
  parameter int DATA_W = 16
) ();
  logic              c1_rd_en;
  logic [9:0]        c1_rd_addr0;
  logic [9:0]        c1_rd_addr1;
  logic [DATA_W-1:0] c1_rd_data0;
  logic [DATA_W-1:0] c1_rd_data1;
  logic              p1_we0;
  logic              p1_we1;
  logic [7:0]        p1_wr_addr0;
  logic [7:0]        p1_wr_addr1;
  logic [DATA_W-1:0] p1_wr_data0;
  logic [DATA_W-1:0] p1_wr_data1;

  modport master (
    output c1_rd_en, c1_rd_addr0, c1_rd_addr1,
    input  c1_rd_data0, c1_rd_data1,
    output p1_we0, p1_we1, p1_wr_addr0, p1_wr_addr1, p1_wr_data0, p1_wr_data1
  );

  modport slave (
    input  c1_rd_en, c1_rd_addr0, c1_rd_addr1,
    output c1_rd_data0, c1_rd_data1,
    input  p1_we0, p1_we1, p1_wr_addr0, p1_wr_addr1, p1_wr_data0, p1_wr_data1
  );
endinterface

// File: rtl/pool1_ctrl.sv
// pool1_ctrl -- 2x2 signed max-pool sequencer for the first pooling layer.
//
// Scans the IN_W x IN_W conv-1 output through two read ports and writes the
// (IN_W/2) x (IN_W/2) pooled result into P1 memory through two write ports.
// Lane 0 produces output rows 0..5 (P1 addr 0..71), lane 1 rows 6..11
// (P1 addr 72..143); both lanes run in lockstep off one FSM.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-low reset
//   start  in   one-cycle pulse, starts a pass when idle (ignored while busy)
//   bus    if   pool1_ctrl_if.master: conv read ports + P1 write ports
//   busy   out  pass in progress
//   done   out  sticky pass-complete flag, cleared by the next accepted start
//
// Build option: define POOL1_RELU_EN to clamp negative write data to 0
// (fused ReLU). The max itself is always taken on unclamped values.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; done holds the result of the last pass
// READ  | four read strobes, tap k = 0..3 (dy = k[1], dx = k[0])
// WAIT  | RD_LAT cycles, no strobes, last tap data drains into max
// WRITE | one write per lane with the window max, then next window
// FIN   | one cycle after the last write; busy=0, done=1
module pool1_ctrl #(
  parameter int IN_W   = 24,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  pool1_ctrl_if.master   bus,
  output logic           busy,
  output logic           done
);

  localparam int OUT_W = IN_W / 2;
  localparam int LANE_ROWS = OUT_W / 2;
  localparam logic [7:0] LANE1_BASE = 8'(LANE_ROWS * OUT_W);
  localparam logic [3:0] LAST_COL = 4'(OUT_W - 1);
  localparam logic [3:0] LAST_ROW = 4'(LANE_ROWS - 1);
  localparam logic [3:0] ROW_OFS = 4'(LANE_ROWS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t state;

  logic [3:0] orow;
  logic [3:0] ocol;
  logic [1:0] tap;
  logic [1:0] wait_cnt;

  logic [3:0] row_nxt;
  logic [3:0] col_nxt;

  // Delay line aligning (strobe, first tap) with the returning read data.
  logic [RD_LAT-1:0] dl_vld;
  logic [RD_LAT-1:0] dl_first;

  logic signed [DATA_W-1:0] max0;
  logic signed [DATA_W-1:0] max1;
  logic signed [DATA_W-1:0] max0_nxt;
  logic signed [DATA_W-1:0] max1_nxt;

  function automatic logic [9:0] rd_addr_f(input logic [3:0] row, input logic [3:0] col,
                                           input logic [1:0] k);
    logic [9:0] y;
    logic [9:0] x;
    y = {5'd0, row, 1'b0} + {9'd0, k[1]};
    x = {5'd0, col, 1'b0} + {9'd0, k[0]};
    return y * 10'(IN_W) + x;
  endfunction

  function automatic logic [7:0] wr_addr_f(input logic [3:0] row, input logic [3:0] col);
    return {4'd0, row} * 8'(OUT_W) + {4'd0, col};
  endfunction

  function automatic logic [DATA_W-1:0] wr_val(input logic [DATA_W-1:0] v);
`ifdef POOL1_RELU_EN
    return v[DATA_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    col_nxt = ocol + 4'd1;
    row_nxt = orow;
    if (ocol == LAST_COL) begin
      col_nxt = '0;
      row_nxt = orow + 4'd1;
    end
  end

  // The last tap lands on the same edge that enters WRITE, so the write
  // data is taken from the combinational next-max rather than the register.
  always_comb begin
    max0_nxt = max0;
    max1_nxt = max1;
    if (dl_vld[RD_LAT-1]) begin
      if (dl_first[RD_LAT-1] || ($signed(bus.c1_rd_data0) > max0))
        max0_nxt = $signed(bus.c1_rd_data0);
      if (dl_first[RD_LAT-1] || ($signed(bus.c1_rd_data1) > max1))
        max1_nxt = $signed(bus.c1_rd_data1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      orow            <= '0;
      ocol            <= '0;
      tap             <= '0;
      wait_cnt        <= '0;
      dl_vld          <= '0;
      dl_first        <= '0;
      max0            <= '0;
      max1            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      bus.c1_rd_en    <= 1'b0;
      bus.c1_rd_addr0 <= '0;
      bus.c1_rd_addr1 <= '0;
      bus.p1_we0      <= 1'b0;
      bus.p1_we1      <= 1'b0;
      bus.p1_wr_addr0 <= '0;
      bus.p1_wr_addr1 <= LANE1_BASE;
      bus.p1_wr_data0 <= '0;
      bus.p1_wr_data1 <= '0;
    end else begin
      dl_vld[0]   <= bus.c1_rd_en;
      dl_first[0] <= bus.c1_rd_en && (tap == 2'd0);
      for (int i = 1; i < RD_LAT; i++) begin
        dl_vld[i]   <= dl_vld[i-1];
        dl_first[i] <= dl_first[i-1];
      end
      max0 <= max0_nxt;
      max1 <= max1_nxt;

      case (state)
        IDLE: begin
          if (start) begin
            state           <= READ;
            orow            <= '0;
            ocol            <= '0;
            tap             <= 2'd0;
            done            <= 1'b0;
            busy            <= 1'b1;
            bus.c1_rd_en    <= 1'b1;
            bus.c1_rd_addr0 <= rd_addr_f(4'd0, 4'd0, 2'd0);
            bus.c1_rd_addr1 <= rd_addr_f(ROW_OFS, 4'd0, 2'd0);
          end
        end

        READ: begin
          if (tap == 2'd3) begin
            state        <= WAIT;
            tap          <= 2'd0;
            wait_cnt     <= 2'(RD_LAT - 1);
            bus.c1_rd_en <= 1'b0;
          end else begin
            tap             <= tap + 2'd1;
            bus.c1_rd_addr0 <= rd_addr_f(orow, ocol, tap + 2'd1);
            bus.c1_rd_addr1 <= rd_addr_f(orow + ROW_OFS, ocol, tap + 2'd1);
          end
        end

        WAIT: begin
          if (wait_cnt == 2'd0) begin
            state           <= WRITE;
            bus.p1_we0      <= 1'b1;
            bus.p1_we1      <= 1'b1;
            bus.p1_wr_addr0 <= wr_addr_f(orow, ocol);
            bus.p1_wr_addr1 <= wr_addr_f(orow, ocol) + LANE1_BASE;
            bus.p1_wr_data0 <= wr_val(max0_nxt);
            bus.p1_wr_data1 <= wr_val(max1_nxt);
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end

        WRITE: begin
          bus.p1_we0 <= 1'b0;
          bus.p1_we1 <= 1'b0;
          if ((orow == LAST_ROW) && (ocol == LAST_COL)) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state           <= READ;
            orow            <= row_nxt;
            ocol            <= col_nxt;
            tap             <= 2'd0;
            bus.c1_rd_en    <= 1'b1;
            bus.c1_rd_addr0 <= rd_addr_f(row_nxt, col_nxt, 2'd0);
            bus.c1_rd_addr1 <= rd_addr_f(row_nxt + ROW_OFS, col_nxt, 2'd0);
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          bus.c1_rd_en <= 1'b0;
          bus.p1_we0   <= 1'b0;
          bus.p1_we1   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool1_ctrl.sv
// tb_pool1_ctrl -- directed self-checking bench for pool1_ctrl.
// A conv-memory model with RD_LAT read latency feeds the DUT; every pass
// pushes its 72 expected write pairs (cycle, addresses, data) into a
// scoreboard queue, and a monitor pops and compares each DUT write.
module tb_pool1_ctrl #(
  parameter int RD_LAT = 1
);
  localparam int P = 5 + RD_LAT;
  localparam int NPIX = 72;

  typedef struct {
    int          cyc;
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [15:0] d0;
    logic [15:0] d1;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  pool1_ctrl_if #(.DATA_W(16)) bus ();

  pool1_ctrl #(.IN_W(24), .DATA_W(16), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int n_we0 = 0;
  int n_we1 = 0;
  logic [15:0] first_d0;
  exp_t sb[$];
  exp_t e;

  logic signed [15:0] mem [0:575];
  logic [15:0] rp0 [RD_LAT];
  logic [15:0] rp1 [RD_LAT];

  always @(posedge clk) cyc <= cyc + 1;

  // Conv memory: RD_LAT-cycle registered read; a loud junk value when idle.
  always @(posedge clk) begin
    rp0[0] <= bus.c1_rd_en ? mem[bus.c1_rd_addr0] : 16'h7abc;
    rp1[0] <= bus.c1_rd_en ? mem[bus.c1_rd_addr1] : 16'h7abc;
    for (int i = 1; i < RD_LAT; i++) begin
      rp0[i] <= rp0[i-1];
      rp1[i] <= rp1[i-1];
    end
  end
  assign bus.c1_rd_data0 = rp0[RD_LAT-1];
  assign bus.c1_rd_data1 = rp1[RD_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] win_max(input int r, input int c);
    logic signed [15:0] m;
    logic signed [15:0] v;
    m = mem[(2*r)*24 + 2*c];
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        v = mem[(2*r+dy)*24 + 2*c + dx];
        if (v > m) m = v;
      end
    return m;
  endfunction

  function automatic logic [15:0] out_val(input logic [15:0] v);
`ifdef POOL1_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  always @(negedge clk) begin
    if (reset && (bus.p1_we0 || bus.p1_we1)) begin
      if (bus.p1_we0) n_we0++;
      if (bus.p1_we1) n_we1++;
      if (n_we0 == 1) first_d0 = bus.p1_wr_data0;
      chk("sb_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_cyc", 32'(cyc - t0), 32'(e.cyc));
        chk("we_pair", {31'd0, bus.p1_we0 & bus.p1_we1}, 32'd1);
        chk("wr_addr0", {24'd0, bus.p1_wr_addr0}, {24'd0, e.a0});
        chk("wr_addr1", {24'd0, bus.p1_wr_addr1}, {24'd0, e.a1});
        chk("wr_data0", {16'd0, bus.p1_wr_data0}, {16'd0, e.d0});
        chk("wr_data1", {16'd0, bus.p1_wr_data1}, {16'd0, e.d1});
      end
    end
  end

  task automatic start_pass();
    exp_t x;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b1;
    n_we0 = 0;
    n_we1 = 0;
    for (int i = 0; i < NPIX; i++) begin
      x.cyc = (i + 1) * P;
      x.a0 = 8'(i);
      x.a1 = 8'(i + 72);
      x.d0 = out_val(win_max(i / 12, i % 12));
      x.d1 = out_val(win_max(i / 12 + 6, i % 12));
      sb.push_back(x);
    end
  endtask

  task automatic finish_pass(input string tag, input int e1, input int e2);
    int k;
    logic got;
    got = 1'b0;
    k = 0;
    for (int n = 0; n < NPIX * P + 50 && !got; n++) begin
      @(posedge clk);
      #1;
      k = cyc - t0;
      start = (k == e1 || k == e2);
      if (k == 1) begin
        chk({tag, "_busy_k1"}, {31'd0, busy}, 32'd1);
        chk({tag, "_done_clr"}, {31'd0, done}, 32'd0);
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    chk({tag, "_done_cyc"}, 32'(k), 32'(NPIX * P + 1));
    chk({tag, "_busy_fin"}, {31'd0, busy}, 32'd0);
    chk({tag, "_n_we0"}, 32'(n_we0), 32'd72);
    chk({tag, "_n_we_all"}, 32'(n_we0 + n_we1), 32'd144);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_hold_a0"}, {24'd0, bus.p1_wr_addr0}, 32'd71);
    chk({tag, "_hold_a1"}, {24'd0, bus.p1_wr_addr1}, 32'd143);
    chk({tag, "_we_off"}, {31'd0, bus.p1_we0 | bus.p1_we1 | bus.c1_rd_en}, 32'd0);
    chk({tag, "_done_sticky"}, {31'd0, done}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"}, {30'd0, bus.p1_we0, bus.p1_we1}, 32'd0);
    chk({tag, "_rd_en"}, {31'd0, bus.c1_rd_en}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_wa0"}, {24'd0, bus.p1_wr_addr0}, 32'd0);
    chk({tag, "_wa1"}, {24'd0, bus.p1_wr_addr1}, 32'd72);
    chk({tag, "_ra"}, {12'd0, bus.c1_rd_addr0, bus.c1_rd_addr1}, 32'd0);
    chk({tag, "_wd"}, {bus.p1_wr_data0, bus.p1_wr_data1}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    for (int a = 0; a < 576; a++) mem[a] = 16'(a);

    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b1;

    // Ramp data: each window max is its bottom-right pixel.
    start_pass();
    finish_pass("ramp", -1, -1);

    // Signed data, window 0 forced to {-5,-2,-9,-2}; stray starts mid-pass.
    for (int a = 0; a < 576; a++) mem[a] = 16'($urandom);
    mem[0] = -16'sd5;
    mem[1] = -16'sd2;
    mem[24] = -16'sd9;
    mem[25] = -16'sd2;
    start_pass();
    finish_pass("sgn", 50, 200);
`ifdef POOL1_RELU_EN
    chk("sgn_w0", {16'd0, first_d0}, 32'h0000);
`else
    chk("sgn_w0", {16'd0, first_d0}, 32'h0000fffe);
`endif

    // Reset at cycle 100 of a pass, then a clean restart.
    start_pass();
    @(posedge clk);
    #1;
    start = 1'b0;
    while (cyc - t0 < 100) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("mid");
    reset = 1'b1;
    sb.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("mid_idle", {29'd0, bus.c1_rd_en, bus.p1_we0, busy}, 32'd0);
    start_pass();
    finish_pass("restart", -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
